// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the FFT bit-reverse reorder stage (bit-reversed in, natural order out).
// FFT_REORDER_SOF_EN adds din_sof and frame_err.
interface fft_bitrev_reorder_if #(
  parameter int data_resolution = 16
);
  logic                              din_valid;
  logic signed [data_resolution-1:0] din_r;
  logic signed [data_resolution-1:0] din_i;
  logic                              dout_valid;
  logic signed [data_resolution-1:0] dout_r;
  logic signed [data_resolution-1:0] dout_i;
  logic                              dout_sof;
  logic                              dout_eof;
`ifdef FFT_REORDER_SOF_EN
  logic                              din_sof;
  logic                              frame_err;
`endif

  modport master (
`ifdef FFT_REORDER_SOF_EN
    output din_sof,
    input  frame_err,
`endif
    output din_valid, din_r, din_i,
    input  dout_valid, dout_r, dout_i, dout_sof, dout_eof
  );

  modport slave (
`ifdef FFT_REORDER_SOF_EN
    input  din_sof,
    output frame_err,
`endif
    input  din_valid, din_r, din_i,
    output dout_valid, dout_r, dout_i, dout_sof, dout_eof
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer after the last R2^2SDF stage: fills one bank at bit-reversed addresses, drains the other in natural order.
// Optional macro FFT_REORDER_SOF_EN adds din_sof resynchronisation and the frame_err pulse.
module fft_bitrev_reorder #(
  parameter int data_resolution = 16,
  parameter int fft_log2        = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               sys_en,
  fft_bitrev_reorder_if.slave bus
);
  localparam int N  = 1 << fft_log2;
  localparam int MW = 2 * data_resolution;

  typedef logic [fft_log2-1:0] idx_t;
  typedef enum logic {IDLE, READ} state_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  function automatic idx_t bitrev(input idx_t k);
    idx_t r;
    for (int b = 0; b < fft_log2; b++) r[b] = k[fft_log2-1-b];
    return r;
  endfunction

  logic [MW-1:0] bank0 [N];
  logic [MW-1:0] bank1 [N];

  logic   accept;
  logic   rd_start;
  idx_t   waddr;
  idx_t   wcnt_q, wcnt_d;
  logic   wbank_q, wbank_d;
`ifdef FFT_REORDER_SOF_EN
  logic   frame_err_q, frame_err_d;
`endif

  state_t state_q, state_d;
  idx_t   rcnt_q, rcnt_d;

  idx_t   raddr_p0_q, raddr_p0_d;
  logic   rbank_p0_q, rbank_p0_d;
  logic   vld_p0_q, vld_p0_d;
  logic   sof_p0_q, sof_p0_d;
  logic   eof_p0_q, eof_p0_d;

  logic [MW-1:0]                     rdata;
  logic                              dout_valid_q, dout_valid_d;
  logic                              dout_sof_q, dout_sof_d;
  logic                              dout_eof_q, dout_eof_d;
  logic signed [data_resolution-1:0] dout_r_q, dout_r_d;
  logic signed [data_resolution-1:0] dout_i_q, dout_i_d;

  // Write side: sample counter, bank select and frame-complete strobe
  always_comb begin
    accept   = sys_en & bus.din_valid;
    waddr    = bitrev(wcnt_q);
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    rd_start = 1'b0;
`ifdef FFT_REORDER_SOF_EN
    frame_err_d = 1'b0;
    if (accept && bus.din_sof) begin
      // A start marker always restarts the frame; any partial fill is dropped in place.
      waddr       = '0;
      wcnt_d      = idx_t'(1);
      frame_err_d = (wcnt_q != '0);
    end else
`endif
    if (accept) begin
      wcnt_d = wcnt_q + idx_t'(1);
      if (wcnt_q == LAST_IDX) begin
        wbank_d  = ~wbank_q;
        rd_start = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept && !sys_rst) begin
      if (wbank_q) bank1[waddr] <= {bus.din_r, bus.din_i};
      else         bank0[waddr] <= {bus.din_r, bus.din_i};
    end
  end

  // Read FSM: issues N sequential addresses into the drain bank
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    raddr_p0_d = rcnt_q;
    rbank_p0_d = ~wbank_q;
    vld_p0_d   = 1'b0;
    sof_p0_d   = 1'b0;
    eof_p0_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          state_d = READ;
          rcnt_d  = '0;
        end
      end
      READ: begin
        vld_p0_d = 1'b1;
        sof_p0_d = (rcnt_q == '0);
        eof_p0_d = (rcnt_q == LAST_IDX);
        if (rcnt_q == LAST_IDX) begin
          rcnt_d  = '0;
          state_d = rd_start ? READ : IDLE;
        end else begin
          rcnt_d = rcnt_q + idx_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: synchronous bank read lands in the output registers
  always_comb begin
    rdata        = rbank_p0_q ? bank1[raddr_p0_q] : bank0[raddr_p0_q];
    dout_valid_d = vld_p0_q;
    dout_sof_d   = sof_p0_q;
    dout_eof_d   = eof_p0_q;
    dout_r_d     = dout_r_q;
    dout_i_d     = dout_i_q;
    if (vld_p0_q) begin
      dout_r_d = rdata[MW-1 -: data_resolution];
      dout_i_d = rdata[data_resolution-1:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wcnt_q       <= '0;
      wbank_q      <= 1'b0;
      state_q      <= IDLE;
      rcnt_q       <= '0;
      vld_p0_q     <= 1'b0;
      sof_p0_q     <= 1'b0;
      eof_p0_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
      dout_r_q     <= '0;
      dout_i_q     <= '0;
`ifdef FFT_REORDER_SOF_EN
      frame_err_q  <= 1'b0;
`endif
    end else if (sys_en) begin
      wcnt_q       <= wcnt_d;
      wbank_q      <= wbank_d;
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      vld_p0_q     <= vld_p0_d;
      sof_p0_q     <= sof_p0_d;
      eof_p0_q     <= eof_p0_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      dout_eof_q   <= dout_eof_d;
      dout_r_q     <= dout_r_d;
      dout_i_q     <= dout_i_d;
`ifdef FFT_REORDER_SOF_EN
      frame_err_q  <= frame_err_d;
`endif
    end
  end

  // Address and bank are only consumed while vld_p0_q is set, so they need no reset.
  always_ff @(posedge sys_clk) begin
    if (sys_en) begin
      raddr_p0_q <= raddr_p0_d;
      rbank_p0_q <= rbank_p0_d;
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_sof   = dout_sof_q;
  assign bus.dout_eof   = dout_eof_q;
  assign bus.dout_r     = dout_r_q;
  assign bus.dout_i     = dout_i_q;
`ifdef FFT_REORDER_SOF_EN
  assign bus.frame_err  = frame_err_q;
`endif

  // A new frame can only complete as the running drain issues its last address.
  rate_guard: assert property (@(posedge sys_clk) disable iff (sys_rst)
    (sys_en && rd_start && state_q == READ) |-> (rcnt_q == LAST_IDX));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder (N=16): directed frames with hand-derived natural-order results.
module tb_fft_bitrev_reorder;
  localparam int DW = 16;

  typedef struct {
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
    bit                   sof;
    bit                   eof;
    int                   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  fft_bitrev_reorder_if #(.data_resolution(DW)) bus ();

  fft_bitrev_reorder #(.data_resolution(DW), .fft_log2(4)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .sys_en  (en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ecnt = 0;
  logic  edge_en = 1'b0;
  logic  edge_rst = 1'b1;
  bit    expect_zero = 1'b0;
  int    ferr_cnt = 0;

  string req_name;
  int    req_act, req_exp;
  int    req_seq = 0;
  int    srv_seq = 0;

  logic                 snap_ok = 1'b0;
  logic                 s_valid, s_sof, s_eof;
  logic signed [DW-1:0] s_r, s_i;

  always @(posedge clk) begin
    edge_en  <= en;
    edge_rst <= rst;
    if (en && !rst) ecnt <= ecnt + 1;
  end

  // Monitor: pops the scoreboard on every freshly presented output sample
  always @(negedge clk) begin
    exp_t e;
    if (req_seq != srv_seq) begin
      srv_seq = req_seq;
      checks++;
      if (req_act != req_exp) begin
        errors++;
        $display("FAIL %s: got %0d want %0d", req_name, req_act, req_exp);
      end
    end
    if (snap_ok && !edge_en && !edge_rst) begin
      checks++;
      if ({bus.dout_valid, bus.dout_sof, bus.dout_eof, bus.dout_r, bus.dout_i} !==
          {s_valid, s_sof, s_eof, s_r, s_i}) begin
        errors++;
        $display("FAIL hold: got v%b r%0d i%0d want v%b r%0d i%0d",
                 bus.dout_valid, bus.dout_r, bus.dout_i, s_valid, s_r, s_i);
      end
    end
    if (expect_zero) begin
      checks++;
      if (bus.dout_valid !== 1'b0 || bus.dout_sof !== 1'b0 || bus.dout_eof !== 1'b0 ||
          bus.dout_r !== '0 || bus.dout_i !== '0) begin
        errors++;
        $display("FAIL idle_zero: got v%b s%b e%b r%0d i%0d want all 0",
                 bus.dout_valid, bus.dout_sof, bus.dout_eof, bus.dout_r, bus.dout_i);
      end
    end
    if (edge_en && !edge_rst && bus.dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got r%0d i%0d want no output", bus.dout_r, bus.dout_i);
      end else begin
        e = exp_q.pop_front();
        if (bus.dout_r !== e.r || bus.dout_i !== e.i || bus.dout_sof !== e.sof ||
            bus.dout_eof !== e.eof || ecnt != e.due) begin
          errors++;
          $display("FAIL sample: got r%0d i%0d s%b e%b cyc%0d want r%0d i%0d s%b e%b cyc%0d",
                   bus.dout_r, bus.dout_i, bus.dout_sof, bus.dout_eof, ecnt,
                   e.r, e.i, e.sof, e.eof, e.due);
        end
      end
    end
`ifdef FFT_REORDER_SOF_EN
    if (edge_en && !edge_rst && bus.frame_err === 1'b1) ferr_cnt++;
`endif
    s_valid = bus.dout_valid; s_sof = bus.dout_sof; s_eof = bus.dout_eof;
    s_r = bus.dout_r; s_i = bus.dout_i;
    snap_ok = 1'b1;
  end

  function automatic int brev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req_check(input string name, input int act, input int expv);
    req_name = name;
    req_act  = act;
    req_exp  = expv;
    req_seq++;
    cyc();
  endtask

  // Input k carries bitrev4(k)+off, so natural-order output j must read j+off.
  task automatic send_frame(input int off, input bit gaps, input bit sof_first);
    exp_t e;
    int   due0;
    for (int k = 0; k < 16; k++) begin
      if (gaps && k > 0) begin
        bus.din_valid = 1'b0;
        cyc();
      end
      bus.din_valid = 1'b1;
      bus.din_r = 16'(brev4(k) + off);
      bus.din_i = 16'(-(brev4(k) + off));
`ifdef FFT_REORDER_SOF_EN
      bus.din_sof = sof_first && (k == 0);
`endif
      if (k == 15) begin
        expect_zero = 1'b0;
        due0 = ecnt + 3;
        for (int j = 0; j < 16; j++) begin
          e.r = 16'(j + off);
          e.i = 16'(-(j + off));
          e.sof = (j == 0);
          e.eof = (j == 15);
          e.due = due0 + j;
          exp_q.push_back(e);
        end
      end
      cyc();
    end
    bus.din_valid = 1'b0;
`ifdef FFT_REORDER_SOF_EN
    bus.din_sof = 1'b0;
`endif
    if (!sof_first && gaps) bus.din_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    cyc();
    req_check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    bus.din_valid = 1'b0;
    bus.din_r = '0;
    bus.din_i = '0;
`ifdef FFT_REORDER_SOF_EN
    bus.din_sof = 1'b0;
`endif
    cyc();
    expect_zero = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc();

    // Single frame, ramp values
    send_frame(0, 1'b0, 1'b0);
    wait_empty();

    // Three contiguous frames, banks reused
    send_frame(100, 1'b0, 1'b0);
    send_frame(200, 1'b0, 1'b0);
    send_frame(300, 1'b0, 1'b0);
    wait_empty();

    // Gapped fill overlapping the previous drain
    send_frame(50, 1'b0, 1'b0);
    send_frame(0, 1'b1, 1'b0);
    wait_empty();

    // Clock enable dropped mid-drain
    send_frame(400, 1'b0, 1'b0);
    repeat (6) cyc();
    en = 1'b0;
    repeat (5) cyc();
    en = 1'b1;
    wait_empty();

    // Reset after a partial frame
    for (int k = 0; k < 7; k++) begin
      bus.din_valid = 1'b1;
      bus.din_r = 16'(500 + k);
      bus.din_i = 16'(-500 - k);
      cyc();
    end
    bus.din_valid = 1'b0;
    rst = 1'b1;
    cyc();
    expect_zero = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    send_frame(600, 1'b0, 1'b0);
    wait_empty();

`ifdef FFT_REORDER_SOF_EN
    // Early start marker discards a 5-sample partial frame
    for (int k = 0; k < 5; k++) begin
      bus.din_valid = 1'b1;
      bus.din_sof = (k == 0);
      bus.din_r = 16'(800 + k);
      bus.din_i = 16'(-800 - k);
      cyc();
    end
    bus.din_valid = 1'b0;
    bus.din_sof = 1'b0;
    cyc();
    req_check("frame_err_clean_sof", ferr_cnt, 0);
    send_frame(700, 1'b0, 1'b1);
    wait_empty();
    req_check("frame_err_pulses", ferr_cnt, 1);
`endif

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder stage placed after the last bf2i/bf2ii stage of the R2²SDF FFT pipeline.
- Accepts one complex sample per enabled cycle in bit-reversed order and emits each frame in natural order.
- Ping-pong double buffer: one bank fills at bit-reversed addresses while the other drains sequentially.
- Adds frame markers for downstream consumers.

Parameters:
- data_resolution, 16, bit width of each real/imag component (two's complement, passed through unmodified).
- fft_log2, 4, log2 of FFT length; N = 2**fft_log2, legal range 2..12.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- sys_en  in  1  global clock enable; when low, all state including memories holds.
- din_valid  in  1  input sample qualifier; a sample is accepted when sys_en & din_valid.
- din_r  in  data_resolution  input real part (bit-reversed frame order).
- din_i  in  data_resolution  input imaginary part.
- dout_valid  out  1  output sample qualifier.
- dout_r  out  data_resolution  output real part (natural order).
- dout_i  out  data_resolution  output imaginary part.
- dout_sof  out  1  high with output index 0.
- dout_eof  out  1  high with output index N-1.

Behaviour:
- Storage: two banks of N×(2·data_resolution) with synchronous read; wbank bit selects the fill bank, the other bank is the drain bank.
- Write side: wcnt (fft_log2 bits) counts accepted samples. Accepted sample k is written to fill-bank address bitrev(k), a full bit-reverse over fft_log2 bits. wcnt increments only on accept.
- Frame end: when wcnt==N-1 is accepted, wcnt wraps to 0, wbank toggles and rd_start pulses for one enabled cycle. No gaps are required between frames.
- Read FSM, IDLE: waits for rd_start. On rd_start it moves to READ with rcnt=0.
- Read FSM, READ: issues address rcnt on every sys_en cycle, regardless of din_valid. After issuing N-1 it returns to IDLE, or stays in READ with rcnt=0 if rd_start occurs in that same cycle (back-to-back frames).
- Output pipeline: the read address is registered, then the data is registered. The first dout_valid appears 2 enabled cycles after the cycle that accepted the last input sample.
- Output stream: samples are emitted on N consecutive enabled cycles. dout_sof aligns with rcnt==0 data and dout_eof with rcnt==N-1 data.
- Rate guarantee: a drain takes exactly N enabled cycles and a fill takes at least N, so the drain bank is always finished before it becomes the fill bank again. No overflow flag is needed; this is a property to assert in verification.
- sys_en low: freezes wcnt, rcnt, FSM, the pipeline registers and all outputs (dout_* hold their values, including dout_valid).
- Reset: wcnt=0, rcnt=0, wbank=0, FSM=IDLE, pipeline cleared. dout_valid=0, dout_sof=0, dout_eof=0, dout_r=0, dout_i=0.
- Reset mid-frame: a partially filled frame and any in-progress drain are discarded. Memory contents are not cleared, but no stale data is ever flagged valid.
- Data: never modified or rescaled; bit-exact pass-through.

Optional Feature:
- Macro: FFT_REORDER_SOF_EN.
- Defined: adds input din_sof (1 bit, qualified by sys_en & din_valid) and output frame_err (1 bit, reset 0).
  - An accepted sample with din_sof=1 is always treated as k=0: written to address 0, wcnt set to 1.
  - If wcnt!=0 at that moment, the partial frame is discarded (no swap, no rd_start) and frame_err pulses high for one enabled cycle.
  - din_sof=1 with wcnt==0 is normal and gives no error.
- Undefined: no din_sof/frame_err ports; wcnt free-runs modulo N from reset.

Test Plan:
1. N=16, 16 back-to-back valid samples with din_r=bitrev4(k), din_i=-bitrev4(k) -> dout_r=0..15 and dout_i=0,-1..-15 in order, first dout_valid 2 cycles after last accept, dout_sof with 0, dout_eof with 15.
2. Three frames continuous (48 consecutive accepts) -> 48 contiguous dout_valid cycles, each frame in natural order, no gap, no data corruption from bank reuse.
3. din_valid toggled 1-0-1-0 during a frame -> output identical to test 1; the drain of the previous frame is unaffected by input gaps.
4. sys_en low for 5 cycles mid-drain -> dout_* hold stable for 5 cycles, then the sequence resumes with no skipped or repeated index.
5. sys_rst asserted after 7 samples accepted, then a full frame sent -> only the new frame appears; dout_valid=0 and outputs=0 during and after reset until the frame completes.
6. With FFT_REORDER_SOF_EN: din_sof at k=0, 5 samples, then din_sof again -> frame_err pulses once; the next 16 samples output correctly. Without the macro: build compiles and test 1 passes.
